pc_secuenciador: RTL
====================

Name: pc_secuenciador

Overview:
- Program-counter controller for the 64-bit fetch stage.
- Owns the PC register and sequences instruction-memory requests.
- Selects the next PC from three sources: sequential increment (PC + PASO), taken-branch redirect, or hold on stall or halt.
- Counts accepted fetches for debug and performance.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
PASO, 4, sequential increment in bytes (64-bit unsigned add)
ANCHO_CUENTA, 32, width of fetch counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  pipeline stall; no new fetch while high
salto_tomado  input  1  taken-branch redirect strobe
bus_direccion_salto  input  64  branch target address
halt  input  1  stop fetching; only reset exits
im_ack  input  1  instruction memory accepted current request (valid only while im_req=1)
im_req  output  1  fetch request to instruction memory
bus_direccion_im  output  64  current PC / fetch address
bus_pc_next  output  64  combinational PC + PASO
pc_valido  output  1  one-cycle pulse: fetch at previous PC completed
cuenta_instr  output  ANCHO_CUENTA  accepted-fetch counter
error_alineacion  output  1  sticky misaligned-target flag (see optional feature)

Behaviour:
- Reset (sampled on clk rising edge when reset=1) sets the following:
  - PC = RESET_PC, state = INICIO, im_req = 0, pc_valido = 0, cuenta_instr = 0, error_alineacion = 0.
  - Reset overrides every other input, including mid-request.
- States: INICIO, BUSCA, DETENIDO.
- INICIO:
  - im_req = 0 for exactly one cycle, then go to BUSCA.
  - halt=1 in this cycle goes to DETENIDO instead.
- BUSCA, evaluated each cycle in this priority order:
  1. halt=1: go to DETENIDO, im_req = 0 next cycle, PC unchanged. An im_ack in the same cycle is ignored.
  2. salto_tomado=1: PC <= bus_direccion_salto next cycle. Any ack this cycle is discarded (no pc_valido, no count). im_req is low for one cycle, then fetching resumes at the target.
  3. stall=1: im_req = 0 (combinationally), PC held, ack ignored.
  4. Otherwise im_req = 1. On im_ack=1:
     - PC <= PC + PASO.
     - pc_valido = 1 in the next cycle.
     - cuenta_instr increments.
  5. Without im_ack, im_req stays high and PC is held (back-to-back wait).
- im_req and bus_direccion_im timing:
  - im_req = (state==BUSCA) & !stall & !salto_tomado & !halt & !redirect_bubble.
  - bus_direccion_im = PC register, stable for the whole request.
- Consecutive acks give one fetch per cycle. Latency from ack to the PC update is 1 cycle.
- DETENIDO: im_req = 0, PC frozen, pc_valido = 0. All inputs except reset are ignored.
- Arithmetic:
  - bus_pc_next = PC + PASO modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  - cuenta_instr wraps modulo 2^ANCHO_CUENTA without flagging.
- Simultaneous salto_tomado and stall: the redirect wins, PC loads the target, and the stall then holds at the new PC.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - On a redirect in BUSCA whose target has bits [1:0] != 2'b00, PC is not loaded.
  - error_alineacion <= 1 (sticky until reset) and the state goes to DETENIDO.
- Undefined:
  - Target bits [1:0] are forced to 2'b00 on load.
  - error_alineacion is tied to 0.

Test Plan:
- Reset with RESET_PC=0, im_ack tied 1:
  - First im_req appears in cycle 2 at address 0.
  - Addresses then run 0, 4, 8, 12, with pc_valido pulsing each cycle.
  - cuenta_instr=4 after 4 acks.
- im_ack held 0 for 3 cycles at PC=0x100: im_req stays 1 and address stays 0x100. When ack arrives, PC becomes 0x104 and the counter increments by 1.
- Branch with ack in the same cycle at PC=0x20, target 0x400:
  - The ack is ignored and the counter is unchanged.
  - One bubble cycle with im_req=0, then a request at 0x400.
- PC=64'hFFFF_FFFF_FFFF_FFFC, ack: next PC=0 and bus_pc_next=4. Then stall=1 for 2 cycles: im_req=0 and PC stays 0.
- halt asserted mid-request: im_req=0 from the next cycle, and further acks, branches and stalls have no effect. reset then returns PC to RESET_PC and the counter to 0.
- Target 0x402 with PC_ALIGN_CHECK_EN defined: error_alineacion=1, state DETENIDO, PC unchanged. Undefined: PC loads 0x400 and the error flag stays 0.

Source files
------------

// File: rtl/pc_secuenciador.sv
// Program-counter sequencer for the 64-bit fetch stage: owns the PC, issues fetch requests, counts accepted fetches.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN (default: target low bits are cleared).
module pc_secuenciador #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int unsigned PASO         = 4,
    parameter int unsigned ANCHO_CUENTA = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    salto_tomado,
    input  logic [63:0]             bus_direccion_salto,
    input  logic                    halt,
    input  logic                    im_ack,
    output logic                    im_req,
    output logic [63:0]             bus_direccion_im,
    output logic [63:0]             bus_pc_next,
    output logic                    pc_valido,
    output logic [ANCHO_CUENTA-1:0] cuenta_instr,
    output logic                    error_alineacion
);

    typedef enum logic [1:0] {
        INICIO   = 2'b00,
        BUSCA    = 2'b01,
        DETENIDO = 2'b10
    } estado_t;

    localparam logic [63:0] PASO_64 = 64'(PASO);

`ifdef PC_ALIGN_CHECK_EN
    localparam logic CHEQUEO_ALINEACION = 1'b1;
`else
    localparam logic CHEQUEO_ALINEACION = 1'b0;
`endif

    estado_t                 estado_r;
    estado_t                 estado_next_s;
    logic [63:0]             pc_r;
    logic [63:0]             pc_next_s;
    logic                    burbuja_r;
    logic                    burbuja_next_s;
    logic                    pc_valido_r;
    logic                    pc_valido_next_s;
    logic [ANCHO_CUENTA-1:0] cuenta_r;
    logic [ANCHO_CUENTA-1:0] cuenta_next_s;
    logic                    error_r;
    logic                    error_next_s;
    logic                    req_s;
    logic                    acepta_s;
    logic                    desalineado_s;
    logic                    trap_s;
    logic [63:0]             destino_s;
    logic [63:0]             pc_mas_paso_s;

    assign pc_mas_paso_s = pc_r + PASO_64;
    assign desalineado_s = |bus_direccion_salto[1:0];
    assign trap_s        = CHEQUEO_ALINEACION & desalineado_s;
    // Without the trap, a misaligned target is silently rounded down to a word boundary.
    assign destino_s     = CHEQUEO_ALINEACION ? bus_direccion_salto
                                              : {bus_direccion_salto[63:2], 2'b00};

    assign req_s    = (estado_r == BUSCA) & ~stall & ~salto_tomado & ~halt & ~burbuja_r;
    assign acepta_s = req_s & im_ack;

    assign im_req           = req_s;
    assign bus_direccion_im = pc_r;
    assign bus_pc_next      = pc_mas_paso_s;
    assign pc_valido        = pc_valido_r;
    assign cuenta_instr     = cuenta_r;
    assign error_alineacion = error_r;

    // Next-state logic: halt beats redirect, redirect beats stall/ack.
    always_comb begin
        estado_next_s    = estado_r;
        pc_next_s        = pc_r;
        burbuja_next_s   = 1'b0;
        pc_valido_next_s = 1'b0;
        cuenta_next_s    = cuenta_r;
        error_next_s     = error_r;
        case (estado_r)
            INICIO: begin
                if (halt) begin
                    estado_next_s = DETENIDO;
                end else begin
                    estado_next_s = BUSCA;
                end
            end
            BUSCA: begin
                if (halt) begin
                    estado_next_s = DETENIDO;
                end else if (salto_tomado) begin
                    if (trap_s) begin
                        error_next_s  = 1'b1;
                        estado_next_s = DETENIDO;
                    end else begin
                        pc_next_s      = destino_s;
                        burbuja_next_s = 1'b1;
                    end
                end else if (acepta_s) begin
                    pc_next_s        = pc_mas_paso_s;
                    pc_valido_next_s = 1'b1;
                    cuenta_next_s    = cuenta_r + ANCHO_CUENTA'(1'b1);
                end else begin
                    pc_next_s = pc_r;
                end
            end
            DETENIDO: begin
                estado_next_s = DETENIDO;
            end
            default: begin
                estado_next_s = INICIO;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r    <= INICIO;
            pc_r        <= RESET_PC;
            burbuja_r   <= 1'b0;
            pc_valido_r <= 1'b0;
            cuenta_r    <= {ANCHO_CUENTA{1'b0}};
            error_r     <= 1'b0;
        end else begin
            estado_r    <= estado_next_s;
            pc_r        <= pc_next_s;
            burbuja_r   <= burbuja_next_s;
            pc_valido_r <= pc_valido_next_s;
            cuenta_r    <= cuenta_next_s;
            error_r     <= error_next_s;
        end
    end

endmodule
